// File: rtl/dc_err_store_pkg.sv
// rtl/dc_err_store_pkg.sv - shared widths, derr byte offsets, lane indices, states
package dc_err_store_pkg;

  localparam int ERR_W = 8;

  // byte offsets of each error inside the 48-bit derr bus
  localparam int U_ERR1 = 0;
  localparam int U_ERR2 = 8;
  localparam int U_ERR3 = 16;
  localparam int V_ERR1 = 24;
  localparam int V_ERR2 = 32;
  localparam int V_ERR3 = 40;

  // byte lanes of the 32-bit top and left words
  localparam int LANE_U0 = 0;
  localparam int LANE_U1 = 1;
  localparam int LANE_V0 = 2;
  localparam int LANE_V1 = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CALC  = 4'b0010,
    S_WRITE = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  // floor(3*err3/4) evaluated two bits wider so -128 and 127 cannot overflow
  function automatic logic [ERR_W-1:0] split_left1(input logic [ERR_W-1:0] e3);
    logic signed [ERR_W+1:0] ext;
    logic signed [ERR_W+1:0] prod;
    ext  = signed'({{2{e3[ERR_W-1]}}, e3});
    prod = (ext <<< 1) + ext;
    prod = prod >>> 2;
    return prod[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/dc_err_ram.sv
// rtl/dc_err_ram.sv - 1R1W synchronous top-error RAM, registered read, read-before-write
module dc_err_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int IW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  // read sees the array before this edge's write lands; out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (32'(raddr) < DEPTH) ? mem[raddr[IW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/dc_err_store.sv
// rtl/dc_err_store.sv - chroma DC diffusion error store: left register plus per-column top RAM
module dc_err_store
  import dc_err_store_pkg::*;
#(
  parameter int MB_COLS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        store,
  input  logic [9:0]  x,
  input  logic [47:0] derr,
  input  logic        top_derr_en,
  input  logic [9:0]  top_derr_addr,
  output logic [31:0] top_derr,
  output logic [31:0] left_derr,
  output logic        busy,
  output logic        done
);

  state_t      state;
  state_t      state_next;
  logic [9:0]  x_q;
  logic [47:0] derr_q;
  logic [31:0] pend_q;
  logic [31:0] left_q;
  logic [31:0] left_word;
  logic [31:0] top_word;
  logic [ERR_W-1:0] u_left1;
  logic [ERR_W-1:0] v_left1;
  logic        ram_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (store) state_next = S_CALC;
      S_CALC:  state_next = S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (frame_start) begin
      state_next = S_IDLE;
    end
  end

  always_comb begin
    u_left1   = split_left1(derr_q[U_ERR3 +: ERR_W]);
    v_left1   = split_left1(derr_q[V_ERR3 +: ERR_W]);
    left_word = '0;
    top_word  = '0;
    left_word[LANE_U0*ERR_W +: ERR_W] = derr_q[U_ERR1 +: ERR_W];
    left_word[LANE_U1*ERR_W +: ERR_W] = u_left1;
    left_word[LANE_V0*ERR_W +: ERR_W] = derr_q[V_ERR1 +: ERR_W];
    left_word[LANE_V1*ERR_W +: ERR_W] = v_left1;
    top_word[LANE_U0*ERR_W +: ERR_W]  = derr_q[U_ERR2 +: ERR_W];
    top_word[LANE_U1*ERR_W +: ERR_W]  = derr_q[U_ERR3 +: ERR_W] - u_left1;
    top_word[LANE_V0*ERR_W +: ERR_W]  = derr_q[V_ERR2 +: ERR_W];
    top_word[LANE_V1*ERR_W +: ERR_W]  = derr_q[V_ERR3 +: ERR_W] - v_left1;
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && store && !frame_start) begin
      x_q    <= x;
      derr_q <= derr;
    end
    if (state == S_CALC) begin
      pend_q <= top_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      left_q <= '0;
    end else if (state == S_CALC) begin
      left_q <= left_word;
    end
  end

  // a frame restart during WRITE must not let the stale word reach the RAM
  assign ram_we = (state == S_WRITE) && !frame_start && !rst;

  dc_err_ram #(
    .DEPTH(MB_COLS),
    .AW   (10),
    .DW   (32)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(x_q),
    .wdata(pend_q),
    .re   (top_derr_en),
    .raddr(top_derr_addr),
    .rdata(top_derr)
  );

  assign left_derr = left_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
